mdu_param: RTL

- Parametrised multiply/divide unit (HI/LO pair) for the E stage; successor to the fixed 32-bit XALU.
- Adds configurable operand width and per-class latency, multiply-accumulate/subtract ops, and a snapshot/rollback path.
- Rollback lets CP0 cancel an HI/LO-modifying instruction that is flushed by an interrupt in M.
- CPU drives `start` only when `busy` is low and no interrupt is pending; it stalls D on `busy`.

---
 rtl/mdu_param_if.sv | 14 +
 rtl/mdu_param.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mdu_param_if.sv
// Handshake/data bundle between the E-stage control and the HI/LO multiply/divide unit.
interface mdu_param_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rollback;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, rollback, input busy, hi, lo);
  modport slave  (input start, op, a, b, rollback, output busy, hi, lo);
endinterface

// File: rtl/mdu_param.sv
// Parametrised HI/LO multiply/divide unit with fixed per-class latency and a
// single-level snapshot that lets CP0 cancel the most recent HI/LO-modifying op.
module mdu_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_param_if.slave  bus
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic [2*WIDTH-1:0] snap_q, snap_d;
  logic               snap_vld_q, snap_vld_d;

  logic               is_signed, accept, neg_a, neg_b;
  logic [2*WIDTH-1:0] acc, ext_a, ext_b, prod, mul_res, div_res;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_u, rem_u, quo, rem;

  always_comb begin
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    acc   = {hi_q, lo_q};
    ext_a = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    ext_b = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    // Product of the extended operands truncated to 2*WIDTH is the exact signed/unsigned product.
    prod  = ext_a * ext_b;
    case (bus.op)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase

    // Sign-magnitude divide: MIN/-1 falls out as MIN with a zero remainder.
    neg_a = is_signed && bus.a[WIDTH-1];
    neg_b = is_signed && bus.b[WIDTH-1];
    mag_a = neg_a ? -bus.a : bus.a;
    mag_b = neg_b ? -bus.b : bus.b;
    quo_u = (mag_b == '0) ? '0 : mag_a / mag_b;
    rem_u = (mag_b == '0) ? '0 : mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? -quo_u : quo_u;
    rem   = neg_a ? -rem_u : rem_u;
    div_res = (bus.b == '0) ? acc : {rem, quo};
  end

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    accept     = bus.start && !busy_q && !bus.rollback &&
                 (bus.op >= OP_MULT) && (bus.op <= OP_MSUBU);

    if (bus.rollback && snap_vld_q) begin
      {hi_d, lo_d} = snap_q;
      busy_d       = 1'b0;
      cnt_d        = '0;
      pend_d       = '0;
      snap_vld_d   = 1'b0;
    end else if (accept) begin
      snap_d     = acc;
      snap_vld_d = 1'b1;
      case (bus.op)
        OP_MTHI: hi_d = bus.a;
        OP_MTLO: lo_d = bus.a;
        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          pend_d = mul_res;
          cnt_d  = MULT_N;
          busy_d = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          pend_d = div_res;
          cnt_d  = DIV_N;
          busy_d = 1'b1;
        end
        default: ;
      endcase
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d       = 1'b0;
        {hi_d, lo_d} = pend_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
